regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count (power of two, at least 2).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 SHALL have parameter NUM_WR, default 2, number of write ports.
REQ-005 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port rs_addr_i  in  NUM_RD x AW  read addresses.
REQ-008 SHALL have port rs_data_o  out  NUM_RD x DATA_W  read data.
REQ-009 SHALL have port rs_busy_o  out  NUM_RD  per-port scoreboard pending bit.
REQ-010 SHALL have port wr_en_i  in  NUM_WR  write enables.
REQ-011 SHALL have port wr_addr_i  in  NUM_WR x AW  write addresses.
REQ-012 SHALL have port wr_data_i  in  NUM_WR x DATA_W  write data.
REQ-013 SHALL have port alloc_en_i  in  1  marks a register as having a pending producer.
REQ-014 SHALL have port alloc_addr_i  in  AW  address to mark pending.

Function
REQ-015 SHALL read combinationally: rs_data_o[p] = regs[rs_addr_i[p]], with zero-cycle latency.
REQ-016 SHALL hold register 0 at zero at all times: writes to it are ignored, reads return 0, its busy bit is 0, and alloc to it is ignored.
REQ-017 SHALL, for each write port with wr_en_i set and a nonzero address, store wr_data_i into the addressed register at the next edge.
REQ-018 SHALL, when multiple write ports target the same address in one cycle, store the highest-indexed port's data.
REQ-019 SHALL keep a busy bit per register: alloc_en_i sets it at the next edge, and any write to that address clears it at the next edge.
REQ-020 SHALL, when an alloc and a write hit the same address in the same cycle, store the write data and leave the busy bit set (the new producer wins).
REQ-021 SHALL drive rs_busy_o[p] = busy[rs_addr_i[p]] from registered state, except as modified by REQ-026.
REQ-022 SHALL update writes to distinct addresses in the same cycle independently and all at the same edge.

Reset
REQ-023 SHALL, while rst_i is high, immediately clear every register and busy bit, regardless of the clock.
REQ-024 SHALL, during reset, drive rs_data_o to 0 and rs_busy_o to 0.
REQ-025 SHALL ignore writes and allocs issued during the cycle in which rst_i deasserts only if rst_i is still high at the edge; the first edge with rst_i low SHALL perform normal updates.

Configuration
REQ-026 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle write data (highest-index matching port) to any read port with a matching nonzero address, and drive that port's rs_busy_o to 0 unless alloc_en_i targets the same address in that cycle.
REQ-027 SHALL, without REGFILE_BYPASS_EN, return only stored values, so that new data and the cleared busy bit become visible one cycle after the write.

Structure
REQ-028 SHALL define AW = $clog2(NUM_REGS) and the address/data typedefs in the shared package regfile_pkg.
REQ-029 SHALL implement the per-read-port lookup (storage mux plus optional bypass) as sub-module regfile_rd_port, instantiated NUM_RD times.

Verification
REQ-030 SHALL cover: reset, then write 0xDEADBEEF to x5 on port 0 -> the next cycle, a read of x5 returns 0xDEADBEEF and x0 reads 0.
REQ-031 SHALL cover: write 0x1 on port 0 and 0x2 on port 1, both to x7 in the same cycle -> x7 = 0x2.
REQ-032 SHALL cover: alloc x9, then hold for 3 cycles -> busy stays 1; write x9 = 0x55 -> busy is 0 the next cycle and the data is 0x55.
REQ-033 SHALL cover: alloc x3 and write x3 = 0xAA in the same cycle -> x3 = 0xAA and busy(x3) = 1.
REQ-034 SHALL cover: with REGFILE_BYPASS_EN, write x4 = 0x1234 while reading x4 -> same cycle rs_data_o = 0x1234; without the macro, the old value is returned that cycle and 0x1234 the next.
REQ-035 SHALL cover: assert rst_i mid-operation, between clock edges, with x1 = 0xFF and busy -> outputs are 0 immediately and remain 0 after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-ported register file.
// The REGFILE_BYPASS_EN macro (used by regfile_rd_port) enables same-cycle write forwarding.
package regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int AW          = $clog2(RF_NUM_REGS);

  typedef logic [AW-1:0]        addr_t;
  typedef logic [RF_DATA_W-1:0] data_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: storage mux plus, with REGFILE_BYPASS_EN defined, same-cycle write forwarding.
// Outputs are forced to zero while reset is held.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int NUM_WR   = 2,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                                rst_i,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]     regs_i,
  input  logic [NUM_REGS-1:0]                 busy_i,
  input  logic [ADDR_W-1:0]                   rs_addr_i,
  input  logic [NUM_WR-1:0]                   wr_en_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]       wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_W-1:0]       wr_data_i,
  input  logic                                alloc_en_i,
  input  logic [ADDR_W-1:0]                   alloc_addr_i,
  output logic [DATA_W-1:0]                   rs_data_o,
  output logic                                rs_busy_o
);

`ifdef REGFILE_BYPASS_EN
  // Later ports overwrite earlier ones, so the highest-indexed matching writer is forwarded.
  always_comb begin
    rs_data_o = regs_i[rs_addr_i];
    rs_busy_o = busy_i[rs_addr_i];
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w] == rs_addr_i) && (rs_addr_i != '0)) begin
        rs_data_o = wr_data_i[w];
        rs_busy_o = alloc_en_i && (alloc_addr_i == rs_addr_i);
      end
    end
    if (rst_i) begin
      rs_data_o = '0;
      rs_busy_o = 1'b0;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i};

  always_comb begin
    rs_data_o = regs_i[rs_addr_i];
    rs_busy_o = busy_i[rs_addr_i];
    if (rst_i) begin
      rs_data_o = '0;
      rs_busy_o = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register pending (busy) scoreboard; x0 is hardwired zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]      rs_addr_i,
  output logic [NUM_RD-1:0][DATA_W-1:0]      rs_data_o,
  output logic [NUM_RD-1:0]                  rs_busy_o,
  input  logic [NUM_WR-1:0]                  wr_en_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]      wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_W-1:0]      wr_data_i,
  input  logic                               alloc_en_i,
  input  logic [ADDR_W-1:0]                  alloc_addr_i
);

  // Register 0 has no storage at all; it is spliced in as a constant below.
  logic [NUM_REGS-1:1][DATA_W-1:0] store_q;
  logic [NUM_REGS-1:1]             busy_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_view;
  logic [NUM_REGS-1:0]             busy_view;

  assign regs_view = {store_q, {DATA_W{1'b0}}};
  assign busy_view = {busy_q, 1'b0};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      store_q <= '0;
      busy_q  <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w] == ADDR_W'(r))) begin
            store_q[r] <= wr_data_i[w];
            busy_q[r]  <= 1'b0;
          end
        end
        // A new producer allocated in the same cycle as a write keeps the register pending.
        if (alloc_en_i && (alloc_addr_i == ADDR_W'(r))) begin
          busy_q[r] <= 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .NUM_WR  (NUM_WR)
    ) u_rd_port (
      .rst_i       (rst_i),
      .regs_i      (regs_view),
      .busy_i      (busy_view),
      .rs_addr_i   (rs_addr_i[p]),
      .wr_en_i     (wr_en_i),
      .wr_addr_i   (wr_addr_i),
      .wr_data_i   (wr_data_i),
      .alloc_en_i  (alloc_en_i),
      .alloc_addr_i(alloc_addr_i),
      .rs_data_o   (rs_data_o[p]),
      .rs_busy_o   (rs_busy_o[p])
    );
  end

endmodule
